mem_bus_arbiter: RTL and testbench

- Shares one external memory/bus port between the instruction fetch port (IF stage) and the data port (MEM stage) of the 5-stage core.
- Feeds imem_ready and dmem_ready straight back to the pipeline hazard/stall logic.
- Data port has priority, with an anti-starvation limit so fetch is guaranteed progress.
- Adds a bus timeout that completes a hung transaction with an error.

---
 rtl/mem_bus_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one external bus between fetch and data ports.
// Data wins ties, bounded by a burst limit; hung transfers time out.
module mem_bus_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int DATA_BURST_MAX = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                imem_valid,
  input  logic [ADDR_W-1:0]   imem_addr,
  output logic [DATA_W-1:0]   imem_rdata,
  output logic                imem_ready,
  output logic                imem_err,
  input  logic                dmem_valid,
  input  logic                dmem_we,
  input  logic [DATA_W/8-1:0] dmem_wstrb,
  input  logic [ADDR_W-1:0]   dmem_addr,
  input  logic [DATA_W-1:0]   dmem_wdata,
  output logic [DATA_W-1:0]   dmem_rdata,
  output logic                dmem_ready,
  output logic                dmem_err,
  output logic                bus_valid,
  output logic                bus_we,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_ready
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [3:0]  BURST_MAX = 4'(DATA_BURST_MAX);
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         burst_q, burst_d;
  logic [15:0]        tmo_q, tmo_d;
  logic               bus_valid_q, bus_valid_d;
  logic               bus_we_q, bus_we_d;
  logic [STRB_W-1:0]  bus_wstrb_q, bus_wstrb_d;
  logic [ADDR_W-1:0]  bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]  bus_wdata_q, bus_wdata_d;

  logic dgnt_ok;
  logic tmo_hit;
  logic done;

  assign dgnt_ok = dmem_valid && !(imem_valid && burst_q == BURST_MAX);
  // bus_ready in the last wait cycle still counts as a normal completion
  assign tmo_hit = (tmo_q == TMO_LAST) && !bus_ready;
  assign done    = bus_ready || tmo_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      burst_q     <= '0;
      tmo_q       <= '0;
      bus_valid_q <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_wstrb_q <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      burst_q     <= burst_d;
      tmo_q       <= tmo_d;
      bus_valid_q <= bus_valid_d;
      bus_we_q    <= bus_we_d;
      bus_wstrb_q <= bus_wstrb_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    burst_d     = burst_q;
    tmo_d       = tmo_q;
    bus_valid_d = bus_valid_q;
    bus_we_d    = bus_we_q;
    bus_wstrb_d = bus_wstrb_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (dgnt_ok) begin
          state_d     = DGNT;
          tmo_d       = '0;
          bus_valid_d = 1'b1;
          bus_we_d    = dmem_we;
          bus_wstrb_d = dmem_wstrb;
          bus_addr_d  = dmem_addr;
          bus_wdata_d = dmem_wdata;
          if (!imem_valid)
            burst_d = '0;
          else if (burst_q != BURST_MAX)
            burst_d = burst_q + 4'd1;
        end else if (imem_valid) begin
          state_d     = IGNT;
          tmo_d       = '0;
          burst_d     = '0;
          bus_valid_d = 1'b1;
          bus_we_d    = 1'b0;
          bus_wstrb_d = '1;
          bus_addr_d  = imem_addr;
          bus_wdata_d = '0;
        end
      end
      IGNT, DGNT: begin
        if (done) begin
          state_d     = IDLE;
          tmo_d       = '0;
          bus_valid_d = 1'b0;
          bus_we_d    = 1'b0;
          bus_wstrb_d = '0;
          bus_addr_d  = '0;
          bus_wdata_d = '0;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_ready = 1'b0;
    imem_err   = 1'b0;
    imem_rdata = '0;
    dmem_ready = 1'b0;
    dmem_err   = 1'b0;
    dmem_rdata = '0;
    unique case (state_q)
      IGNT: begin
        imem_ready = done;
        imem_err   = tmo_hit;
        imem_rdata = bus_ready ? bus_rdata : '0;
      end
      DGNT: begin
        dmem_ready = done;
        dmem_err   = tmo_hit;
        dmem_rdata = bus_ready ? bus_rdata : '0;
      end
      default: ;
    endcase
  end

  assign bus_valid = bus_valid_q;
  assign bus_we    = bus_we_q;
  assign bus_wstrb = bus_wstrb_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter.
// Burst limit 4, timeout 8 cycles.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        imem_err;
  logic        dmem_valid;
  logic        dmem_we;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        dmem_err;
  logic        bus_valid;
  logic        bus_we;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;

  int n_cmp = 0;
  int n_bad = 0;

  mem_bus_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .DATA_BURST_MAX(4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_valid(imem_valid),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .imem_ready(imem_ready),
    .imem_err(imem_err),
    .dmem_valid(dmem_valid),
    .dmem_we(dmem_we),
    .dmem_wstrb(dmem_wstrb),
    .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready),
    .dmem_err(dmem_err),
    .bus_valid(bus_valid),
    .bus_we(bus_we),
    .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_ready(bus_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    imem_valid = 1'b1;
    imem_addr = 32'h100;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({bus_valid, bus_we, bus_wstrb, bus_addr, bus_wdata} !== 70'd0) begin
        n_bad++;
        $display("FAIL reset_bus[%0d] got v=%b a=%h need 0", i, bus_valid, bus_addr);
      end
      n_cmp++;
      if ({imem_ready, dmem_ready, imem_err, dmem_err} !== 4'b0) begin
        n_bad++;
        $display("FAIL reset_ready[%0d] got i=%b d=%b need 0", i, imem_ready, dmem_ready);
      end
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (bus_valid !== 1'b1 || bus_addr !== 32'h100) begin
      n_bad++;
      $display("FAIL reset_release got v=%b a=%h need 1/00000100", bus_valid, bus_addr);
    end
    bus_ready = 1'b1;
    bus_rdata = 32'h11;
    #1;
    n_cmp++;
    if (imem_ready !== 1'b1 || imem_rdata !== 32'h11) begin
      n_bad++;
      $display("FAIL reset_first_fetch got r=%b d=%h need 1/00000011", imem_ready, imem_rdata);
    end
    tick();
    imem_valid = 1'b0;
    bus_ready = 1'b0;
    bus_rdata = '0;
    #1;
    n_cmp++;
    if (bus_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_done_idle got v=%b need 0", bus_valid);
    end
  endtask

  task automatic test_single_fetch();
    imem_valid = 1'b1;
    imem_addr = 32'h104;
    tick();
    n_cmp++;
    if ({bus_valid, bus_we, bus_wstrb, bus_addr, bus_wdata} !== {1'b1, 1'b0, 4'hF, 32'h104, 32'h0}) begin
      n_bad++;
      $display("FAIL fetch_bus got v=%b we=%b s=%h a=%h w=%h need 1/0/f/104/0",
               bus_valid, bus_we, bus_wstrb, bus_addr, bus_wdata);
    end
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (imem_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL fetch_wait[%0d] got ready=%b need 0", i, imem_ready);
      end
      tick();
    end
    bus_ready = 1'b1;
    bus_rdata = 32'h00500093;
    #1;
    n_cmp++;
    if ({imem_ready, imem_err, imem_rdata, dmem_ready} !== {1'b1, 1'b0, 32'h00500093, 1'b0}) begin
      n_bad++;
      $display("FAIL fetch_done got r=%b e=%b d=%h dr=%b need 1/0/00500093/0",
               imem_ready, imem_err, imem_rdata, dmem_ready);
    end
    tick();
    bus_ready = 1'b0;
    bus_rdata = '0;
    n_cmp++;
    if (imem_ready !== 1'b0 || bus_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL fetch_idle got r=%b v=%b need 0/0", imem_ready, bus_valid);
    end
    imem_valid = 1'b0;
    tick();
  endtask

  task automatic test_priority();
    imem_valid = 1'b1;
    imem_addr = 32'h108;
    dmem_valid = 1'b1;
    dmem_we = 1'b1;
    dmem_addr = 32'h2000;
    dmem_wdata = 32'hDEADBEEF;
    dmem_wstrb = 4'hF;
    tick();
    n_cmp++;
    if ({bus_valid, bus_we, bus_addr, bus_wdata} !== {1'b1, 1'b1, 32'h2000, 32'hDEADBEEF}) begin
      n_bad++;
      $display("FAIL prio_data_first got v=%b we=%b a=%h w=%h need 1/1/2000/deadbeef",
               bus_valid, bus_we, bus_addr, bus_wdata);
    end
    bus_ready = 1'b1;
    #1;
    n_cmp++;
    if (dmem_ready !== 1'b1 || imem_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL prio_data_done got d=%b i=%b need 1/0", dmem_ready, imem_ready);
    end
    tick();
    dmem_valid = 1'b0;
    bus_ready = 1'b0;
    n_cmp++;
    if (bus_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL prio_dead_cycle got v=%b need 0", bus_valid);
    end
    tick();
    n_cmp++;
    if ({bus_valid, bus_we, bus_addr} !== {1'b1, 1'b0, 32'h108}) begin
      n_bad++;
      $display("FAIL prio_fetch_next got v=%b we=%b a=%h need 1/0/108", bus_valid, bus_we, bus_addr);
    end
    bus_ready = 1'b1;
    tick();
    imem_valid = 1'b0;
    bus_ready = 1'b0;
  endtask

  task automatic test_starvation();
    logic [31:0] exp_a [6];
    exp_a = '{32'h4000, 32'h4000, 32'h4000, 32'h4000, 32'h10C, 32'h4000};
    imem_valid = 1'b1;
    imem_addr = 32'h10C;
    dmem_valid = 1'b1;
    dmem_we = 1'b0;
    dmem_addr = 32'h4000;
    bus_ready = 1'b1;
    for (int g = 0; g < 6; g++) begin
      tick();
      n_cmp++;
      if (bus_valid !== 1'b1 || bus_addr !== exp_a[g]) begin
        n_bad++;
        $display("FAIL starve_grant[%0d] got v=%b a=%h need 1/%h", g, bus_valid, bus_addr, exp_a[g]);
      end
      n_cmp++;
      if (imem_ready !== (exp_a[g] == 32'h10C) || dmem_ready !== (exp_a[g] != 32'h10C)) begin
        n_bad++;
        $display("FAIL starve_ready[%0d] got i=%b d=%b", g, imem_ready, dmem_ready);
      end
      tick();
      n_cmp++;
      if (bus_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL starve_idle[%0d] got v=%b need 0", g, bus_valid);
      end
    end
    imem_valid = 1'b0;
    dmem_valid = 1'b0;
    bus_ready = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    dmem_valid = 1'b1;
    dmem_we = 1'b0;
    dmem_addr = 32'h3000;
    bus_rdata = 32'hAAAA5555;
    tick();
    for (int c = 1; c < 8; c++) begin
      n_cmp++;
      if (dmem_ready !== 1'b0 || bus_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL tmo_wait[%0d] got r=%b v=%b need 0/1", c, dmem_ready, bus_valid);
      end
      tick();
    end
    n_cmp++;
    if ({dmem_ready, dmem_err, dmem_rdata} !== {1'b1, 1'b1, 32'h0}) begin
      n_bad++;
      $display("FAIL tmo_fire got r=%b e=%b d=%h need 1/1/0", dmem_ready, dmem_err, dmem_rdata);
    end
    tick();
    dmem_valid = 1'b0;
    n_cmp++;
    if (bus_valid !== 1'b0 || dmem_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL tmo_release got v=%b r=%b need 0/0", bus_valid, dmem_ready);
    end
    dmem_valid = 1'b1;
    tick();
    for (int c = 1; c < 8; c++) tick();
    bus_ready = 1'b1;
    bus_rdata = 32'h12345678;
    #1;
    n_cmp++;
    if ({dmem_ready, dmem_err, dmem_rdata} !== {1'b1, 1'b0, 32'h12345678}) begin
      n_bad++;
      $display("FAIL tmo_late_ready got r=%b e=%b d=%h need 1/0/12345678",
               dmem_ready, dmem_err, dmem_rdata);
    end
    tick();
    dmem_valid = 1'b0;
    bus_ready = 1'b0;
    bus_rdata = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp_a [5];
    exp_a = '{32'h5000, 32'h5000, 32'h5000, 32'h5000, 32'h200};
    imem_valid = 1'b1;
    imem_addr = 32'h200;
    dmem_valid = 1'b1;
    dmem_we = 1'b1;
    dmem_addr = 32'h5000;
    dmem_wdata = 32'h0;
    tick();
    n_cmp++;
    if (bus_valid !== 1'b1 || bus_addr !== 32'h5000) begin
      n_bad++;
      $display("FAIL mid_grant got v=%b a=%h need 1/5000", bus_valid, bus_addr);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dmem_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_no_pulse got r=%b need 0", dmem_ready);
    end
    tick();
    n_cmp++;
    if (bus_valid !== 1'b0 || dmem_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset got v=%b r=%b need 0/0", bus_valid, dmem_ready);
    end
    rst_n = 1'b1;
    bus_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      tick();
      n_cmp++;
      if (bus_valid !== 1'b1 || bus_addr !== exp_a[g]) begin
        n_bad++;
        $display("FAIL mid_burst[%0d] got v=%b a=%h need 1/%h", g, bus_valid, bus_addr, exp_a[g]);
      end
      tick();
    end
    imem_valid = 1'b0;
    dmem_valid = 1'b0;
    bus_ready = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    imem_valid = 1'b0;
    imem_addr = '0;
    dmem_valid = 1'b0;
    dmem_we = 1'b0;
    dmem_wstrb = '0;
    dmem_addr = '0;
    dmem_wdata = '0;
    bus_rdata = '0;
    bus_ready = 1'b0;
    test_reset();
    test_single_fetch();
    test_priority();
    test_starvation();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
